// File: rtl/keypad_pkg.sv
// keypad_pkg: scanner state enum, column priority encoder and key-code width helper
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HOLD} kp_state_e;
  function automatic int key_code_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction
  function automatic int lowest_set_index(input logic [31:0] v);
    lowest_set_index = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) lowest_set_index = i;
  endfunction
endpackage

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: synchronous FIFO (clk, rst, push/din in, pop/dout out, full/empty/count status)
module keypad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_matrix_controller.sv
// keypad_matrix_controller: row scan + press/release debounce feeding a key-code FIFO (enable, cols, ack in; rows, key_code, valid, overflow, fill out)
module keypad_matrix_controller
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DWELL = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [COLS-1:0]                      cols,
  output logic [ROWS-1:0]                      rows,
  output logic [key_code_width(ROWS, COLS)-1:0] key_code,
  output logic                                 valid,
  input  logic                                 ack,
  output logic                                 overflow,
  output logic [$clog2(FIFO_DEPTH):0]          fill
);
  localparam int KW = key_code_width(ROWS, COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DWW = $clog2(SCAN_DWELL + 1);
  localparam int CTW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DWW-1:0] DWELL_LAST = DWW'(SCAN_DWELL - 1);
  localparam logic [CTW-1:0] CNT_LAST = CTW'(DEBOUNCE_CYCLES - 1);
  kp_state_e state_q, state_d;
  logic [RW-1:0] row_q, row_d, row_nxt;
  logic [CW-1:0] col_q, col_d, low_col;
  logic [DWW-1:0] dwell_q, dwell_d;
  logic [CTW-1:0] cnt_q, cnt_d;
  logic [ROWS-1:0] rows_q, rows_d;
  logic overflow_q, overflow_d;
  logic cols_any, col_match, push, pop_ok, full, empty;
  logic [KW-1:0] push_code;
  assign cols_any = |cols;
  assign low_col = CW'(lowest_set_index(32'(cols)));
  assign col_match = cols_any && low_col == col_q;
  assign row_nxt = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
  assign push_code = KW'(int'(row_q) * COLS + int'(col_q));
  assign valid = !empty;
  assign pop_ok = ack && valid;
  assign rows = rows_q;
  assign overflow = overflow_q;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    dwell_d = dwell_q;
    cnt_d = cnt_q;
    push = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      row_d = '0;
      col_d = '0;
      dwell_d = '0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          row_d = '0;
          dwell_d = '0;
          cnt_d = '0;
        end
        SCAN:
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            if (cols_any) begin
              state_d = DEBOUNCE;
              col_d = low_col;
              cnt_d = '0;
            end else row_d = row_nxt;
          end else dwell_d = dwell_q + 1'b1;
        DEBOUNCE:
          if (!col_match) begin
            state_d = SCAN;
            row_d = row_nxt;
            dwell_d = '0;
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            push = 1'b1;
            state_d = HOLD;
            cnt_d = '0;
          end else cnt_d = cnt_q + 1'b1;
        HOLD:
          if (cols_any) cnt_d = '0;
          else if (cnt_q == CNT_LAST) begin
            state_d = SCAN;
            row_d = row_nxt;
            dwell_d = '0;
            cnt_d = '0;
          end else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
    rows_d = (state_d == IDLE) ? '0 : ROWS'(1) << row_d;
    // a drop needs a full FIFO with no pop freeing a slot on the same edge
    overflow_d = (push && full && !pop_ok) ? 1'b1 : pop_ok ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      dwell_q <= '0;
      cnt_q <= '0;
      rows_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      dwell_q <= dwell_d;
      cnt_q <= cnt_d;
      rows_q <= rows_d;
      overflow_q <= overflow_d;
    end
  keypad_key_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(KW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(push_code),
    .pop(ack),
    .dout(key_code),
    .full(full),
    .empty(empty),
    .count(fill)
  );
endmodule

// File: doc/keypad_matrix_controller.md
# keypad_matrix_controller

Parametrised matrix-keypad front end for the calculator datapath. It drives the keypad rows one at a time, senses the columns, and debounces both press and release. Each confirmed press is encoded as a linear key index and queued in a small FIFO. The FIFO is drained by the calculator control FSM through a valid/ack handshake, so keys pressed while the consumer is busy are buffered rather than lost.

## Interface
Parameters:
- ROWS, 4, number of keypad rows (≥2)
- COLS, 4, number of keypad columns (≥2)
- SCAN_DWELL, 4, cycles each row is driven before columns are sampled (≥1)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to confirm press or release (≥2)
- FIFO_DEPTH, 4, key-code buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- enable  in  1  scanning enabled while high
- cols  in  COLS  column sense lines, active-high, already synchronised upstream
- rows  out  ROWS  row drive, one-hot active-high; all-zero when not scanning
- key_code  out  $clog2(ROWS*COLS)  head-of-FIFO key index = row*COLS + col
- valid  out  1  FIFO non-empty; key_code meaningful
- ack  in  1  consumer pops the head on a clock edge where valid && ack
- overflow  out  1  sticky: a confirmed key was dropped because the FIFO was full
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- FSM states: IDLE, SCAN, DEBOUNCE, HOLD.
- IDLE: rows=0. Moves to SCAN with row index 0 when enable=1.
- SCAN: drives row r for SCAN_DWELL cycles.
  - On the last dwell cycle, if cols≠0: capture c = lowest set column index and go to DEBOUNCE, keeping row r driven.
  - Otherwise advance r (wraps from ROWS-1 to 0) and restart the dwell.
- DEBOUNCE: a counter increments each cycle in which the lowest set column still equals c.
  - Any mismatch, including cols=0, returns to SCAN at row (r+1) mod ROWS. No push occurs.
  - When the count reaches DEBOUNCE_CYCLES: push r*COLS+c and go to HOLD.
- HOLD: row r stays driven. The counter counts consecutive cycles with cols=0 and clears on any nonzero cols. On reaching DEBOUNCE_CYCLES, go to SCAN at row (r+1) mod ROWS. A held key therefore produces exactly one code.
- Multiple keys in one row: the lowest column wins. Keys in different rows are reported in scan order, one at a time, each after the previous key is released.
- enable falling in any state: IDLE on the next edge, rows=0, counters cleared. FIFO contents and overflow are retained.
- FIFO:
  - Push and pop in the same cycle are both performed, including when the FIFO is full; occupancy is then unchanged.
  - Push when full without a simultaneous pop: the code is dropped and overflow is set.
  - overflow clears on the first accepted pop (valid && ack).
  - ack while valid=0 is ignored.

## Timing
- Reset values: state=IDLE, rows=0, key_code=0, valid=0, overflow=0, fill=0, FIFO pointers and counters 0. Reset may assert mid-operation; every register returns to these values immediately.
- rows, valid, fill, overflow and key_code are registered outputs. key_code is read from the FIFO head with no extra cycle.
- Press latency: the DEBOUNCE entry edge is followed by DEBOUNCE_CYCLES stable cycles. The push happens on the edge ending the last of these cycles, and valid rises on that same edge.
- Pop: the head advances on the ack edge, and the next entry appears on key_code on that edge.
- Worst-case detection delay from a stable press to DEBOUNCE entry: ROWS*SCAN_DWELL cycles.

## Structure
- Package keypad_pkg holds:
  - the kp_state_e enum (IDLE, SCAN, DEBOUNCE, HOLD)
  - the function lowest_set_index(cols) used for the column priority encode
  - the localparam helper for key-code width
- Sub-module keypad_key_fifo: a parametrised synchronous FIFO (DEPTH, WIDTH) with push, pop, full, empty and count ports.
- The scanner FSM and counters live in keypad_matrix_controller.

## Test plan
- Defaults; hold row 2 col 1 steady for 40 cycles and then release → exactly one code, 9; valid rises DEBOUNCE_CYCLES edges after DEBOUNCE entry; ack clears valid.
- Bounce: toggle col 3 on row 0 every 5 cycles for 60 cycles, then hold it stable → no push during bouncing; single code 3 after the stable window.
- Row 1, cols 0 and 2 together → code 4 only. Release, then press row 3 col 3 → code 15.
- FIFO_DEPTH=4, ack tied 0, five distinct presses → fill=4, overflow=1, codes 1..4 retained. One ack → overflow=0, key_code=2.
- Full FIFO with ack held during a new confirmation → pop and push both happen, fill stays 4, overflow stays 0.
- Drop enable during DEBOUNCE, and assert rst during HOLD → rows=0 the next cycle; no code pushed; all outputs at reset values after rst.
